// File: rtl/muldiv_sequencer.sv
// Sequencer for the shared mult/div datapath: runs the selected unit for a fixed number
// of cycles, steers the operand and Hi/Lo source muxes, then commits or raises an exception.
module muldiv_sequencer #(
    parameter int MULT_CYCLES = 33,
    parameter int DIV_CYCLES  = 33,
    parameter int CNT_W       = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       op_start,
    input  logic [1:0] op_sel,
    input  logic       div_zero,
    output logic       mult_ctrl,
    output logic       div_ctrl,
    output logic       DIVASelect,
    output logic       DIVBSelect,
    output logic       MDSelect,
    output logic       HiCtrl,
    output logic       LoCtrl,
    output logic       busy,
    output logic       done,
    output logic       div_excpt,
    output logic       bad_op
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] MULT_RUN = 3'd1;
    localparam logic [2:0] DIV_RUN  = 3'd2;
    localparam logic [2:0] WRITE    = 3'd3;
    localparam logic [2:0] EXCPT    = 3'd4;
    localparam logic [2:0] BAD      = 3'd5;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_mult_q, is_mult_d;
    logic             is_divm_q, is_divm_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_mult_d = is_mult_q;
        is_divm_d = is_divm_q;
        case (state_q)
            IDLE: begin
                if (op_start) begin
                    is_mult_d = 1'b0;
                    is_divm_d = 1'b0;
                    case (op_sel)
                        2'b00: begin
                            state_d   = MULT_RUN;
                            cnt_d     = MULT_LOAD;
                            is_mult_d = 1'b1;
                        end
                        2'b01: begin
                            state_d = DIV_RUN;
                            cnt_d   = DIV_LOAD;
                        end
                        2'b10: begin
                            state_d   = DIV_RUN;
                            cnt_d     = DIV_LOAD;
                            is_divm_d = 1'b1;
                        end
                        default: state_d = BAD;
                    endcase
                end
            end
            MULT_RUN: begin
                if (cnt_q == '0) state_d = WRITE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            DIV_RUN: begin
                // divide-by-zero is only meaningful on the first enable cycle
                if (cnt_q == DIV_LOAD && div_zero) state_d = EXCPT;
                else if (cnt_q == '0)              state_d = WRITE;
                else                               cnt_d   = cnt_q - 1'b1;
            end
            WRITE, EXCPT, BAD: begin
                state_d   = IDLE;
                cnt_d     = '0;
                is_mult_d = 1'b0;
                is_divm_d = 1'b0;
            end
            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                is_mult_d = 1'b0;
                is_divm_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_mult_q <= 1'b0;
            is_divm_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_mult_q <= is_mult_d;
            is_divm_q <= is_divm_d;
        end
    end

    // Outputs decode from registered state only; the divisor select stays put until the commit ends.
    assign mult_ctrl  = (state_q == MULT_RUN);
    assign div_ctrl   = (state_q == DIV_RUN);
    assign DIVASelect = 1'b0;
    assign DIVBSelect = is_divm_q && ((state_q == DIV_RUN) || (state_q == WRITE) || (state_q == EXCPT));
    assign MDSelect   = (state_q == WRITE) && is_mult_q;
    assign HiCtrl     = (state_q == WRITE);
    assign LoCtrl     = (state_q == WRITE);
    assign done       = (state_q == WRITE);
    assign busy       = (state_q == MULT_RUN) || (state_q == DIV_RUN) ||
                        (state_q == WRITE) || (state_q == EXCPT);
    assign div_excpt  = (state_q == EXCPT);
    assign bad_op     = (state_q == BAD);

endmodule
